ysyx_22050854_divider: RTL and testbench
========================================

YSYX_22050854_DIVIDER -- requirements
Module: ysyx_22050854_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port div_valid, input, 1 bit: request to start a divide.
REQ-004 SHALL have port div_ready, output, 1 bit: high iff the state is IDLE.
REQ-005 SHALL have port div_signed, input, 1 bit: 1 = DIV/REM semantics, 0 = DIVU/REMU semantics.
REQ-006 SHALL have port divw, input, 1 bit: 1 = word op (W variants) on bits [31:0].
REQ-007 SHALL have port dividend, input, 64 bits: dividend operand.
REQ-008 SHALL have port divisor, input, 64 bits: divisor operand.
REQ-009 SHALL have port flush, input, 1 bit: abort any operation in flight.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle result-ready pulse.
REQ-011 SHALL have port quotient, output, 64 bits: quotient result.
REQ-012 SHALL have port remainder, output, 64 bits: remainder result.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE; out_valid = (state==DONE); div_ready = (state==IDLE).
REQ-014 SHALL accept an operation on a rising edge where state==IDLE, div_valid=1 and flush=0, and SHALL latch div_signed, divw and the operands at that edge.
REQ-015 SHALL, for word ops, sign-extend (signed) or zero-extend (unsigned) operand bits [31:0] before dividing.
REQ-016 SHALL compute on magnitudes: signed operands are replaced by their absolute value at acceptance; |0x8000_0000_0000_0000| = 2^63 unsigned.
REQ-017 SHALL use radix-2 restoring division, one quotient bit per CALC cycle: 64 iterations for 64-bit ops, 32 for word ops.
REQ-018 SHALL enter DONE on the edge that completes the last iteration, so out_valid is high in the cycle that begins 64 edges (word: 32 edges) after the acceptance edge.
REQ-019 SHALL negate the quotient when signed and the operand signs differ.
REQ-020 SHALL negate the remainder when signed and the dividend is negative.
REQ-021 SHALL, for word ops, sign-extend bit 31 of both results to 64 bits.
REQ-022 SHALL, on divide-by-zero, produce quotient = all ones and remainder = the (extended) dividend, for signed and unsigned ops.
REQ-023 SHALL, on signed overflow (MIN / -1), produce quotient = MIN and remainder = 0 (64-bit or word MIN as applicable).
REQ-024 SHALL go DONE -> IDLE after exactly one cycle; a div_valid present during DONE is not accepted.
REQ-025 SHALL hold quotient and remainder stable from DONE until the next acceptance.
REQ-026 SHALL return to IDLE on the next edge when flush=1 in any state, with no out_valid pulse for the aborted operation; flush in DONE suppresses nothing already visible but still forces IDLE.
REQ-027 SHALL give flush priority over div_valid in IDLE: no operation is accepted.

Reset
REQ-028 SHALL, while rst_n=0, immediately force state IDLE, iteration counter 0, quotient 0, remainder 0, out_valid 0 and div_ready 1, including mid-CALC.
REQ-029 SHALL accept an operation on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL use macro YSYX_22050854_DIV_FASTZERO_EN: when defined, a zero divisor detected at acceptance goes IDLE -> DONE in one edge with the REQ-022 results; when undefined, it runs the full 64/32 iterations and still yields the REQ-022 results.

Verification
REQ-031 SHALL cover: unsigned 64-bit 100/7 -> quotient 14, remainder 2, out_valid exactly 64 cycles after acceptance, one cycle wide.
REQ-032 SHALL cover: signed -7/2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1; signed MIN/-1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-033 SHALL cover: divw signed, dividend 0x0000_0001_8000_0000, divisor 0xFFFF_FFFF -> quotient 0x0000_0000_8000_0000 sign-extended to 0xFFFF_FFFF_8000_0000, remainder 0, after 32 cycles.
REQ-034 SHALL cover: divisor 0, dividend 5, unsigned -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5; latency 1 cycle with YSYX_22050854_DIV_FASTZERO_EN defined, 64 cycles without.
REQ-035 SHALL cover: flush asserted at CALC cycle 10 -> IDLE next edge, no out_valid; a new 9/3 op issued immediately afterwards -> quotient 3, remainder 0.
REQ-036 SHALL cover: rst_n pulled low mid-CALC -> outputs zero and div_ready=1 without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_22050854_divider.sv
// rtl/ysyx_22050854_divider.sv - radix-2 restoring divider, 64-bit and word ops (option macro: YSYX_22050854_DIV_FASTZERO_EN)
module ysyx_22050854_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic        divw,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        flush,
    output logic        out_valid,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [5:0]  r_cnt;
    logic [63:0] r_acc;        // partial remainder
    logic [63:0] r_quo;        // dividend bits shift out the top, quotient bits shift in the bottom
    logic [63:0] r_dvs;        // divisor magnitude
    logic [63:0] r_zrem;       // remainder to report if the divisor was zero
    logic        r_word;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dvs_zero;
    logic [63:0] r_quotient;
    logic [63:0] r_remainder;

    logic        w_accept;
    logic [63:0] w_dvd_ext;
    logic [63:0] w_dvs_ext;
    logic        w_dvd_neg;
    logic        w_dvs_neg;
    logic [63:0] w_dvd_mag;
    logic [63:0] w_dvs_mag;
    logic        w_dvs_zero;
    logic [63:0] w_zero_rem;
    logic [64:0] w_trial;
    logic        w_ge;
    logic [63:0] w_acc_nxt;
    logic [63:0] w_quo_nxt;
    logic        w_last;
    logic [63:0] w_q_mag;
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_q_res;
    logic [63:0] w_r_res;

    assign w_accept = (r_state == S_IDLE) && div_valid && !flush;

    // Operand extension for word ops and conversion to unsigned magnitudes
    always_comb begin
        w_dvd_ext  = dividend;
        w_dvs_ext  = divisor;
        w_zero_rem = dividend;
        if (divw) begin
            w_dvd_ext  = {{32{div_signed & dividend[31]}}, dividend[31:0]};
            w_dvs_ext  = {{32{div_signed & divisor[31]}}, divisor[31:0]};
            w_zero_rem = {{32{dividend[31]}}, dividend[31:0]};
        end
        w_dvd_neg  = div_signed & w_dvd_ext[63];
        w_dvs_neg  = div_signed & w_dvs_ext[63];
        w_dvd_mag  = w_dvd_neg ? (64'd0 - w_dvd_ext) : w_dvd_ext;
        w_dvs_mag  = w_dvs_neg ? (64'd0 - w_dvs_ext) : w_dvs_ext;
        w_dvs_zero = (w_dvs_ext == 64'd0);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        w_trial   = {r_acc, r_quo[63]};
        w_ge      = (w_trial >= {1'b0, r_dvs});
        w_acc_nxt = w_ge ? (w_trial[63:0] - r_dvs) : w_trial[63:0];
        w_quo_nxt = {r_quo[62:0], w_ge};
        w_last    = r_word ? (r_cnt == 6'd31) : (r_cnt == 6'd63);
    end

    // Final sign fix-up, divide-by-zero override and word sign-extension
    always_comb begin
        w_q_mag = r_word ? {32'd0, w_quo_nxt[31:0]} : w_quo_nxt;
        w_q_fix = r_neg_q ? (64'd0 - w_q_mag) : w_q_mag;
        w_r_fix = r_neg_r ? (64'd0 - w_acc_nxt) : w_acc_nxt;
        if (r_dvs_zero) begin
            w_q_fix = '1;
            w_r_fix = r_zrem;
        end
        w_q_res = w_q_fix;
        w_r_res = w_r_fix;
        if (r_word) begin
            w_q_res = {{32{w_q_fix[31]}}, w_q_fix[31:0]};
            w_r_res = {{32{w_r_fix[31]}}, w_r_fix[31:0]};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush always wins and returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef YSYX_22050854_DIV_FASTZERO_EN
                    w_state_nxt = w_dvs_zero ? S_DONE : S_CALC;
`else
                    w_state_nxt = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        div_ready = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // Datapath: load on acceptance, iterate in CALC, capture results on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 6'd0;
            r_acc       <= 64'd0;
            r_quo       <= 64'd0;
            r_dvs       <= 64'd0;
            r_zrem      <= 64'd0;
            r_word      <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dvs_zero  <= 1'b0;
            r_quotient  <= 64'd0;
            r_remainder <= 64'd0;
        end else if (w_accept) begin
            r_cnt      <= 6'd0;
            r_acc      <= 64'd0;
            r_quo      <= divw ? {w_dvd_mag[31:0], 32'd0} : w_dvd_mag;
            r_dvs      <= w_dvs_mag;
            r_zrem     <= w_zero_rem;
            r_word     <= divw;
            r_neg_q    <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r    <= w_dvd_neg;
            r_dvs_zero <= w_dvs_zero;
`ifdef YSYX_22050854_DIV_FASTZERO_EN
            if (w_dvs_zero) begin
                r_quotient  <= '1;
                r_remainder <= w_zero_rem;
            end
`endif
        end else if (r_state == S_CALC && !flush) begin
            r_acc <= w_acc_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) begin
                r_quotient  <= w_q_res;
                r_remainder <= w_r_res;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// tb/tb_ysyx_22050854_divider.sv - self-checking bench for ysyx_22050854_divider
module tb_ysyx_22050854_divider;

    logic        clk;
    logic        rst_n;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic        divw;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        flush;
    logic        out_valid;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int checks;
    int failures;

    ysyx_22050854_divider dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .divw       (divw),
        .dividend   (dividend),
        .divisor    (divisor),
        .flush      (flush),
        .out_valid  (out_valid),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit          sgn;
        bit          w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
    } op_t;

    // Reference: RISC-V DIV/DIVU/REM/REMU and W variants using plain arithmetic
    function automatic void ref_div(input bit sgn, input bit w, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] q, output logic [63:0] r);
        logic [31:0] a32, b32, q32, r32;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = '1;
                r32 = a32;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32;
                r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            q = {{32{q32[31]}}, q32};
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0) begin
                q = '1;
                r = a;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
                q = a;
                r = 64'd0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Edges from acceptance to the cycle where out_valid is high
    function automatic int exp_lat(input bit w, input logic [63:0] b);
`ifdef YSYX_22050854_DIV_FASTZERO_EN
        if (w ? (b[31:0] == 32'd0) : (b == 64'd0)) return 0;
`endif
        return w ? 32 : 64;
    endfunction

    // Issue one op, wait (bounded) for out_valid, capture results, probe pulse width and hold
    task automatic do_op(input bit sgn, input bit w, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat,
                         output bit one_wide, output bit held);
        @(negedge clk);
        div_signed = sgn;
        divw       = w;
        dividend   = a;
        divisor    = b;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        lat = -1;
        q = 'x;
        r = 'x;
        one_wide = 1'b0;
        held = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat >= 0) begin
            q = quotient;
            r = remainder;
            @(posedge clk);
            #1;
            one_wide = !out_valid;
            repeat (2) @(posedge clk);
            #1;
            held = (quotient === q) && (remainder === r);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        divw       = 1'b0;
        dividend   = 64'd0;
        divisor    = 64'd0;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", div_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (quotient !== 64'd0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 64'd0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        op_t tbl[7];
        logic [63:0] q, r;
        int lat;
        bit one_wide, held;
        tbl = '{
            '{1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2},
            '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF},
            '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0},
            '{1'b1, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0},
            '{1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5},
            '{1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_9ABC_DEF0},
            '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE}
        };
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].sgn, tbl[i].w, tbl[i].a, tbl[i].b, q, r, lat, one_wide, held);
            checks++; if (q !== tbl[i].q) begin failures++; $display("FAIL directed%0d_quotient got=%h exp=%h", i, q, tbl[i].q); end
            checks++; if (r !== tbl[i].r) begin failures++; $display("FAIL directed%0d_remainder got=%h exp=%h", i, r, tbl[i].r); end
            checks++; if (lat != exp_lat(tbl[i].w, tbl[i].b)) begin failures++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, exp_lat(tbl[i].w, tbl[i].b)); end
            checks++; if (!one_wide) begin failures++; $display("FAIL directed%0d_pulse_width got=wide exp=one_cycle", i); end
            checks++; if (!held) begin failures++; $display("FAIL directed%0d_hold got=changed exp=stable", i); end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, q, r, eq, er;
        bit sgn, w, one_wide, held;
        int lat;
        for (int n = 0; n < 40; n++) begin
            sgn = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            a   = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: b = 64'($urandom_range(1, 15));
                2: b = '1;
                3: b = {$urandom, $urandom};
                4: b = {32'd0, $urandom};
                5: b = {$urandom, $urandom} >> $urandom_range(0, 63);
                default: b = 64'd0 - 64'($urandom_range(1, 100));
            endcase
            case ($urandom_range(0, 7))
                0: a = 64'h8000_0000_0000_0000;
                1: a = 64'h0000_0000_8000_0000;
                2: a = a >> $urandom_range(0, 63);
                default: ;
            endcase
            ref_div(sgn, w, a, b, eq, er);
            do_op(sgn, w, a, b, q, r, lat, one_wide, held);
            checks++; if (q !== eq) begin failures++; $display("FAIL rand%0d_quotient s=%0d w=%0d a=%h b=%h got=%h exp=%h", n, sgn, w, a, b, q, eq); end
            checks++; if (r !== er) begin failures++; $display("FAIL rand%0d_remainder s=%0d w=%0d a=%h b=%h got=%h exp=%h", n, sgn, w, a, b, r, er); end
            checks++; if (lat != exp_lat(w, b)) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, exp_lat(w, b)); end
            checks++; if (!one_wide) begin failures++; $display("FAIL rand%0d_pulse_width got=wide exp=one_cycle", n); end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] q, r;
        int lat;
        bit one_wide, held, seen;
        @(negedge clk);
        div_signed = 1'b0;
        divw       = 1'b0;
        dividend   = 64'd20;
        divisor    = 64'd6;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_done got=timeout exp=out_valid"); end
        dividend  = 64'd50;
        divisor   = 64'd5;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL b2b_valid_in_done got=ready%b exp=ready1", div_ready); end
        checks++; if (quotient !== 64'd3 || remainder !== 64'd2) begin failures++; $display("FAIL b2b_first_result got=%0d,%0d exp=3,2", quotient, remainder); end
        do_op(1'b0, 1'b0, 64'd50, 64'd5, q, r, lat, one_wide, held);
        checks++; if (q !== 64'd10 || r !== 64'd0) begin failures++; $display("FAIL b2b_second_result got=%0d,%0d exp=10,0", q, r); end
    endtask

    task automatic test_flush();
        logic [63:0] q, r;
        int lat;
        bit one_wide, held, seen;
        @(negedge clk);
        div_signed = 1'b0;
        divw       = 1'b0;
        dividend   = 64'd1000;
        divisor    = 64'd3;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL flush_calc_ready got=%b exp=1", div_ready); end
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL flush_calc_no_valid got=pulse exp=none"); end
        do_op(1'b0, 1'b0, 64'd9, 64'd3, q, r, lat, one_wide, held);
        checks++; if (q !== 64'd3) begin failures++; $display("FAIL flush_next_quotient got=%0d exp=3", q); end
        checks++; if (r !== 64'd0) begin failures++; $display("FAIL flush_next_remainder got=%0d exp=0", r); end
        checks++; if (lat != 64) begin failures++; $display("FAIL flush_next_latency got=%0d exp=64", lat); end
        @(negedge clk);
        dividend  = 64'd77;
        divisor   = 64'd7;
        div_valid = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        flush     = 1'b0;
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_priority got=ready%b exp=ready1", div_ready); end
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL flush_idle_no_valid got=pulse exp=none"); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] q, r;
        int lat;
        bit one_wide, held;
        @(negedge clk);
        div_signed = 1'b0;
        divw       = 1'b0;
        dividend   = 64'd12345;
        divisor    = 64'd7;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (quotient !== 64'd0) begin failures++; $display("FAIL midreset_quotient got=%h exp=0", quotient); end
        checks++; if (remainder !== 64'd0) begin failures++; $display("FAIL midreset_remainder got=%h exp=0", remainder); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", div_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", out_valid); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        do_op(1'b0, 1'b0, 64'd100, 64'd7, q, r, lat, one_wide, held);
        checks++; if (q !== 64'd14 || r !== 64'd2) begin failures++; $display("FAIL postreset_result got=%0d,%0d exp=14,2", q, r); end
        checks++; if (lat != 64) begin failures++; $display("FAIL postreset_latency got=%0d exp=64", lat); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
